sram_req_ctrl: RTL and testbench



---
 rtl/sram_req_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
//
// Initiator-side controller for a single-port generic SRAM macro with a fixed
// read latency. Turns a valid/ready request stream into SRAM port cycles and
// returns read data through a response FIFO with valid/ready back-pressure.
//
// Reads are issued only against free response credits. A credit is a FIFO
// slot that is neither occupied nor reserved by a read still travelling
// through the macro's latency pipeline. Every read in flight is therefore
// guaranteed a slot when its data emerges, so no read datum is ever dropped.
// Writes need no response slot and are always accepted.
//
// Addresses at or above NumWords are never forwarded to the macro. An
// out-of-range write is swallowed. An out-of-range read still takes a credit
// and a pipeline slot, so it stays in order with its neighbours, and it comes
// back as data 0 with rsp_err_o set.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_*             request stream (valid/ready, we, addr, wdata, be)
//   rsp_*             read response stream (valid/ready, rdata, err)
//   sram_*            SRAM macro port; sram_rdata_i valid Latency cycles
//                     after a read request (same cycle when Latency = 0)
//   busy_o            reads in the pipeline or responses still buffered
// -----------------------------------------------------------------------------
module sram_req_ctrl #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 3,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,

  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,

  output logic                 busy_o
);

  // FIFO pointer width, occupancy width, and a width wide enough to hold
  // occupancy plus every pipeline stage without overflowing.
  localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW  = $clog2(RspDepth + 1);
  localparam int unsigned SumW  = $clog2(RspDepth + Latency + 1) + 1;
  localparam int unsigned PipeW = (Latency > 0) ? Latency : 1;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  logic                 w_oor;
  logic                 w_acc;
  logic                 w_rd_acc;
  logic                 w_credit_ok;
  logic [PipeW-1:0]     w_pipe_vld;
  logic [SumW-1:0]      w_in_use;

  // FIFO state
  logic [DataWidth-1:0] r_mem_data [RspDepth];
  logic [RspDepth-1:0]  r_mem_err;
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;

  // FIFO push/pop strobes
  logic                 w_push;
  logic                 w_push_err;
  logic [DataWidth-1:0] w_push_data;
  logic                 w_pop;

  // Address compare is done at 32 bits so it stays correct when NumWords is
  // not a power of two (the address bus can then encode illegal words).
  assign w_oor = 32'(req_addr_i) >= NumWords;

  // Slots in use = buffered responses + reads still inside the macro. Both
  // terms come from registers, so a pop only frees its credit next cycle.
  // NOTE: every signal assigned in an always_comb gets a value before any
  // conditional or loop touches it; otherwise synthesis infers a latch.
  always_comb begin
    w_in_use = SumW'(r_count);
    for (int i = 0; i < PipeW; i++) begin
      w_in_use = w_in_use + SumW'(w_pipe_vld[i]);
    end
  end

  assign w_credit_ok = w_in_use < SumW'(RspDepth);

  // Ready is gated by reset so nothing is accepted while the state is cleared.
  assign req_ready_o = rst_ni && (req_we_i || w_credit_ok);
  assign w_acc       = req_valid_i && req_ready_o;
  assign w_rd_acc    = w_acc && !req_we_i;

  // SRAM port is driven in the accept cycle; out-of-range never reaches it.
  assign sram_req_o   = w_acc && !w_oor;
  assign sram_we_o    = sram_req_o && req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // ---------------------------------------------------------------------------
  // Read latency pipeline: one {valid, err} pair per cycle of macro latency.
  // The last stage lines up with sram_rdata_i and feeds the FIFO push.
  // ---------------------------------------------------------------------------
  generate
    if (Latency == 0) begin : g_no_pipe
      // Data is already on sram_rdata_i in the accept cycle.
      assign w_pipe_vld = '0;
      assign w_push     = w_rd_acc;
      assign w_push_err = w_oor;
    end else begin : g_pipe
      logic [Latency-1:0] r_pipe_vld;
      logic [Latency-1:0] r_pipe_err;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the previous stage's value from before this clock edge.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pipe_vld <= '0;
          r_pipe_err <= '0;
        end else begin
          r_pipe_vld[0] <= w_rd_acc;
          r_pipe_err[0] <= w_oor;
          for (int i = 1; i < Latency; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_err[i] <= r_pipe_err[i-1];
          end
        end
      end

      assign w_pipe_vld = r_pipe_vld;
      assign w_push     = r_pipe_vld[Latency-1];
      assign w_push_err = r_pipe_err[Latency-1];
    end
  endgenerate

  // Out-of-range reads return zero instead of whatever is on the bus.
  assign w_push_data = w_push_err ? '0 : sram_rdata_i;

  // ---------------------------------------------------------------------------
  // Response FIFO (no bypass: a pushed entry is visible the following cycle)
  // ---------------------------------------------------------------------------
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rsp_valid_o = (r_count != '0);
  assign w_pop       = rsp_valid_o && rsp_ready_i;

  // NOTE: the storage array has no reset. An entry is only ever observed
  // after it has been written, and the outputs below are forced to zero
  // whenever the FIFO is empty, so stale or unknown contents never escape.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_err[r_wptr]  <= w_push_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The head entry cannot be overwritten while it is displayed because a push
  // into a full FIFO is impossible, so data holds under back-pressure.
  assign rsp_rdata_o = rsp_valid_o ? r_mem_data[r_rptr] : '0;
  assign rsp_err_o   = rsp_valid_o ? r_mem_err[r_rptr]  : 1'b0;

  assign busy_o = (|w_pipe_vld) || rsp_valid_o;

  // Credit accounting guarantees a free slot for every emerging read.
  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(w_push && (r_count == CntW'(RspDepth)))
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_req_ctrl
//
// Directed bench for sram_req_ctrl. Two instances share one behavioural SRAM
// image: "dut" (NumWords=200, Latency=1, RspDepth=3) with a registered-read
// macro model, and "dut0" (NumWords=200, Latency=0, RspDepth=2) with a
// combinational-read model. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge. Cycle N of a scenario is the clock
// period in which its first request is presented.
// -----------------------------------------------------------------------------
module tb_sram_req_ctrl;

  localparam int unsigned NW = 200;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b1;

  always #5 clk = ~clk;

  // dut (Latency = 1)
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [BW-1:0] sram_be;
  logic          busy;

  // dut0 (Latency = 0)
  logic          req_valid0, req_ready0, req_we0;
  logic [AW-1:0] req_addr0;
  logic [DW-1:0] req_wdata0;
  logic [BW-1:0] req_be0;
  logic          rsp_valid0, rsp_ready0, rsp_err0;
  logic [DW-1:0] rsp_rdata0;
  logic          sram_req0, sram_we0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_wdata0, sram_rdata0;
  logic [BW-1:0] sram_be0;
  logic          busy0;

  int n_vec = 0;
  int n_err = 0;

  sram_req_ctrl #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(1), .RspDepth(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .busy_o(busy)
  );

  sram_req_ctrl #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(0), .RspDepth(2)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_be_i(req_be0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0),
    .sram_req_o(sram_req0), .sram_we_o(sram_we0), .sram_addr_o(sram_addr0),
    .sram_wdata_o(sram_wdata0), .sram_be_o(sram_be0), .sram_rdata_i(sram_rdata0),
    .busy_o(busy0)
  );

  // Initial SRAM image.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    if (a == 32) return 32'hFFFF_FFFF;
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // SRAM models: registered read (Latency 1) and combinational read (Latency 0).
  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  assign sram_rdata0 = mem[sram_addr0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a response on dut, check it, then let it pop.
  task automatic wait_rsp(input string tag, input logic [DW-1:0] exp_d, input logic exp_e);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_data"}, 64'(rsp_rdata), 64'(exp_d));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got, first, last;
    logic all_ok, any_v;

    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = 4'hF;
    rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = '0; req_wdata0 = '0; req_be0 = 4'hF;
    rsp_ready0 = 0;

    // ---- reset state (requests presented while in reset are refused) ----
    repeat (2) @(posedge clk);
    #1;
    load = 0;
    req_valid = 1; req_we = 1; req_addr = 8'h10;
    req_valid0 = 1; req_we0 = 0; req_addr0 = 8'h05;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_sram_req", 64'(sram_req), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready0", 64'(req_ready0), 64'd0);
    check("rst_sram_req0", 64'(sram_req0), 64'd0);
    req_valid = 0; req_valid0 = 0;
    tick();
    rst_n = 1;
    tick();

    // ---- single read, Latency 1: response in cycle 2 ----
    rsp_ready = 1;
    req_valid = 1; req_we = 0; req_addr = 8'h10;
    @(negedge clk);
    check("rd_ready", 64'(req_ready), 64'd1);
    check("rd_sram_req", 64'(sram_req), 64'd1);
    check("rd_sram_we", 64'(sram_we), 64'd0);
    check("rd_sram_addr", 64'(sram_addr), 64'h10);
    tick();
    req_valid = 0;
    @(negedge clk);
    check("rd_c1_valid", 64'(rsp_valid), 64'd0);
    check("rd_c1_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("rd_c2_valid", 64'(rsp_valid), 64'd1);
    check("rd_c2_data", 64'(rsp_rdata), 64'hDEAD_BEEF);
    check("rd_c2_err", 64'(rsp_err), 64'd0);
    tick();
    @(negedge clk);
    check("rd_c3_valid", 64'(rsp_valid), 64'd0);
    check("rd_c3_busy", 64'(busy), 64'd0);
    tick();

    // ---- write with partial byte enables, then read back ----
    req_valid = 1; req_we = 1; req_addr = 8'h20; req_wdata = 32'h1234_5678; req_be = 4'b0011;
    @(negedge clk);
    check("wr_sram_req", 64'(sram_req), 64'd1);
    check("wr_sram_we", 64'(sram_we), 64'd1);
    check("wr_sram_be", 64'(sram_be), 64'h3);
    check("wr_sram_wdata", 64'(sram_wdata), 64'h1234_5678);
    tick();
    req_we = 0; req_be = 4'hF;
    @(negedge clk);
    check("wr_rd_sram_we", 64'(sram_we), 64'd0);
    tick();
    req_valid = 0;
    wait_rsp("wr_rd", 32'hFFFF_5678, 1'b0);

    // ---- back-pressure: only RspDepth reads accepted while stalled ----
    rsp_ready = 0;
    k = 0;
    req_valid = 1; req_we = 0; req_addr = 8'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready) k++;
      tick();
      req_addr = AW'(k);
    end
    check("bp_accepted", 64'(k), 64'd3);
    @(negedge clk);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    tick();
    rsp_ready = 1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("bp_rsp_data", 64'(rsp_rdata), 64'(init_val(got)));
        got++;
      end
      if (req_valid && req_ready) k++;
      tick();
      if (k == 5) req_valid = 0;
      else req_addr = AW'(k);
    end
    check("bp_rsp_count", 64'(got), 64'd5);
    tick();

    // ---- streaming: 16 back-to-back reads, one response per cycle ----
    all_ok = 1; got = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        req_valid = 1; req_addr = AW'(64 + c);
      end else begin
        req_valid = 0;
      end
      @(negedge clk);
      if (c < 16 && !req_ready) all_ok = 0;
      if (rsp_valid) begin
        if (got == 0) first = c;
        last = c;
        check("stream_data", 64'(rsp_rdata), 64'(init_val(64 + got)));
        got++;
      end
      tick();
    end
    check("stream_ready", 64'(all_ok), 64'd1);
    check("stream_count", 64'(got), 64'd16);
    check("stream_first", 64'(first), 64'd2);
    check("stream_last", 64'(last), 64'd17);

    // ---- out-of-range read stays in order with err set ----
    rsp_ready = 0;
    req_valid = 1; req_we = 0; req_addr = 8'd5;
    tick();
    req_addr = 8'd210;
    @(negedge clk);
    check("oor_rd_ready", 64'(req_ready), 64'd1);
    check("oor_rd_sram_req", 64'(sram_req), 64'd0);
    tick();
    req_addr = 8'd6;
    tick();
    req_valid = 0;
    rsp_ready = 1;
    wait_rsp("oor_r0", init_val(5), 1'b0);
    wait_rsp("oor_r1", 32'h0, 1'b1);
    wait_rsp("oor_r2", init_val(6), 1'b0);

    // ---- out-of-range write: accepted, dropped, no response ----
    req_valid = 1; req_we = 1; req_addr = 8'd210; req_wdata = 32'hAAAA_5555;
    @(negedge clk);
    check("oor_wr_ready", 64'(req_ready), 64'd1);
    check("oor_wr_sram_req", 64'(sram_req), 64'd0);
    check("oor_wr_sram_we", 64'(sram_we), 64'd0);
    tick();
    req_valid = 0; req_we = 0;
    any_v = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      any_v = any_v | rsp_valid;
      tick();
    end
    check("oor_wr_no_rsp", 64'(any_v), 64'd0);
    check("oor_wr_busy", 64'(busy), 64'd0);

    // ---- reset mid-flight discards everything ----
    rsp_ready = 0; rsp_ready0 = 0;
    req_valid = 1; req_we = 0; req_addr = 8'h11;
    req_valid0 = 1; req_we0 = 0; req_addr0 = 8'd9;
    tick();
    req_addr = 8'h12;
    req_valid0 = 0;
    tick();
    req_valid = 0;
    #1;
    check("mid_pre_busy", 64'(busy), 64'd1);
    check("mid_pre_valid0", 64'(rsp_valid0), 64'd1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid0", 64'(rsp_valid0), 64'd0);
    check("mid_rst_busy0", 64'(busy0), 64'd0);
    tick();
    rst_n = 1;
    rsp_ready = 1; rsp_ready0 = 1;
    any_v = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      any_v = any_v | rsp_valid | rsp_valid0;
      tick();
    end
    check("mid_no_stale", 64'(any_v), 64'd0);

    // ---- Latency 0 after reset: response in cycle 1 ----
    req_valid0 = 1; req_we0 = 0; req_addr0 = 8'd7; req_wdata0 = 32'h0BAD_F00D; req_be0 = 4'h5;
    @(negedge clk);
    check("l0_sram_req", 64'(sram_req0), 64'd1);
    check("l0_sram_we", 64'(sram_we0), 64'd0);
    check("l0_sram_addr", 64'(sram_addr0), 64'd7);
    check("l0_sram_be", 64'(sram_be0), 64'h5);
    check("l0_sram_wdata", 64'(sram_wdata0), 64'h0BAD_F00D);
    check("l0_c0_valid", 64'(rsp_valid0), 64'd0);
    tick();
    req_valid0 = 0;
    @(negedge clk);
    check("l0_c1_valid", 64'(rsp_valid0), 64'd1);
    check("l0_c1_data", 64'(rsp_rdata0), 64'(init_val(7)));
    check("l0_c1_err", 64'(rsp_err0), 64'd0);
    tick();
    @(negedge clk);
    check("l0_c2_valid", 64'(rsp_valid0), 64'd0);
    check("l0_c2_busy", 64'(busy0), 64'd0);
    tick();

    // ---- Latency 1 instance recovers after reset ----
    req_valid = 1; req_we = 0; req_addr = 8'h10;
    tick();
    req_valid = 0;
    wait_rsp("post_rst", 32'hDEAD_BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
